// File: rtl/alu_op_sequencer.sv
// Purpose : issue side of the ALU; decodes one instruction per handshake, drives DATA1/DATA2/SELECT,
//           holds them for the op's settle time, captures RESULT and returns it with a zero flag.
// Latency : result valid ADD_WAIT (ADD/SUB) or LOGIC_WAIT (others) cycles after the accept edge.
// Backpressure: one op in flight; o_instr_ready only in IDLE, result held until i_res_ready.
// Ports   : i_clk/i_rst_n clock and async active-low reset
//           i_instr_valid/o_instr_ready + i_opcode/i_operand1/i_operand2  instruction port
//           o_alu_data1/o_alu_data2/o_alu_select -> ALU, i_alu_result <- ALU
//           o_res_valid/i_res_ready + o_res_data/o_res_zero  result port
//           o_illegal  one-cycle pulse when an undefined opcode is accepted
module alu_op_sequencer #(
   parameter int WIDTH      = 8,
   parameter int ADD_WAIT   = 2,
   parameter int LOGIC_WAIT = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_instr_valid,
   output logic             o_instr_ready,
   input  logic [7:0]       i_opcode,
   input  logic [WIDTH-1:0] i_operand1,
   input  logic [WIDTH-1:0] i_operand2,
   output logic [WIDTH-1:0] o_alu_data1,
   output logic [WIDTH-1:0] o_alu_data2,
   output logic [2:0]       o_alu_select,
   input  logic [WIDTH-1:0] i_alu_result,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [WIDTH-1:0] o_res_data,
   output logic             o_res_zero,
   output logic             o_illegal
);

   localparam int MAX_WAIT = (ADD_WAIT > LOGIC_WAIT) ? ADD_WAIT : LOGIC_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_alu_data1;
   logic [WIDTH-1:0] r_alu_data2;
   logic [2:0]       r_alu_select;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_zero;
   logic             r_illegal;

   logic             w_legal;
   logic [2:0]       w_select;
   logic [WIDTH-1:0] w_data2;
   logic [CNT_W-1:0] w_wait;
   logic             w_accept;

   assign w_accept = i_instr_valid && (r_state == S_IDLE);

   // Opcode decode: SELECT, second ALU operand and settle time for the op.
   always_comb begin
      w_legal  = 1'b1;
      w_select = 3'b000;
      w_data2  = i_operand2;
      w_wait   = CNT_W'(LOGIC_WAIT);
      case (i_opcode)
         8'h00: ;                                    // LOADI: ALU passes DATA2
         8'h01: w_data2 = i_operand1;                // MOV: pass operand1 through DATA2
         8'h02: begin
            w_select = 3'b001;
            w_wait   = CNT_W'(ADD_WAIT);
         end
         8'h03: begin                                // SUB as ADD of the two's complement
            w_select = 3'b001;
            w_data2  = ~i_operand2 + WIDTH'(1);
            w_wait   = CNT_W'(ADD_WAIT);
         end
         8'h04: w_select = 3'b010;
         8'h05: w_select = 3'b011;
         8'h06: begin                                // shift amount lives in the top 3 bits
            w_select = 3'b100;
            w_data2  = {i_operand2[2:0], {(WIDTH-3){1'b0}}};
         end
         default: w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_alu_data1  <= '0;
         r_alu_data2  <= '0;
         r_alu_select <= 3'b000;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_res_zero   <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_legal) begin
                     r_alu_data1  <= i_operand1;
                     r_alu_data2  <= w_data2;
                     r_alu_select <= w_select;
                     r_cnt        <= w_wait;
                     r_state      <= S_WAIT;
                  end else begin
                     // ALU outputs deliberately left as-is so the ALU sees no glitch
                     r_illegal <= 1'b1;
                     r_state   <= S_ERR;
                  end
               end
            end
            S_WAIT: begin
               // Counter holds edges remaining; the edge where it reads 1 is the settle edge.
               if (r_cnt == CNT_W'(1)) begin
                  r_cnt       <= '0;
                  r_res_data  <= i_alu_result;
                  r_res_zero  <= ~|i_alu_result;
                  r_res_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_instr_ready = (r_state == S_IDLE);
   assign o_alu_data1   = r_alu_data1;
   assign o_alu_data2   = r_alu_data2;
   assign o_alu_select  = r_alu_select;
   assign o_res_valid   = r_res_valid;
   assign o_res_data    = r_res_data;
   assign o_res_zero    = r_res_zero;
   assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose : scoreboard bench for alu_op_sequencer with a clocked ALU model and random traffic.
// Latency : n/a (bench).
// Backpressure: result consumer is randomised or forced low/high per phase.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] opcode;
   logic [7:0] op1;
   logic [7:0] op2;
   logic [7:0] alu_d1;
   logic [7:0] alu_d2;
   logic [2:0] alu_sel;
   logic [7:0] alu_res;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_zero;
   logic       illegal;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_instr_valid (instr_valid),
      .o_instr_ready (instr_ready),
      .i_opcode      (opcode),
      .i_operand1    (op1),
      .i_operand2    (op2),
      .o_alu_data1   (alu_d1),
      .o_alu_data2   (alu_d2),
      .o_alu_select  (alu_sel),
      .i_alu_result  (alu_res),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_res_data    (res_data),
      .o_res_zero    (res_zero),
      .o_illegal     (illegal)
   );

   // ALU model: logic ops settle within one cycle, the adder is registered and needs two.
   logic [7:0] alu_comb;
   logic [7:0] add_q;
   always_comb begin
      alu_comb = 8'hEE;
      case (alu_sel)
         3'b000:  alu_comb = alu_d2;
         3'b010:  alu_comb = alu_d1 & alu_d2;
         3'b011:  alu_comb = alu_d1 | alu_d2;
         3'b100:  alu_comb = alu_d1 >> alu_d2[7:5];
         default: alu_comb = 8'hEE;
      endcase
   end
   always @(posedge clk) add_q <= alu_d1 + alu_d2;
   assign alu_res = (alu_sel == 3'b001) ? add_q : alu_comb;

   typedef struct {
      logic [7:0] data;
      logic       zero;
      int         due;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 2;   // 0 random, 1 held low, 2 held high
   int   hs_cyc = -1;
   int   last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      res_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour, straight from the opcode table.
   function automatic bit is_legal(input logic [7:0] op);
      return op <= 8'h06;
   endfunction

   function automatic logic [7:0] ref_result(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         8'h00:   r = b;
         8'h01:   r = a;
         8'h02:   r = a + b;
         8'h03:   r = a - b;
         8'h04:   r = a & b;
         8'h05:   r = a | b;
         default: r = a >> (b % 8);
      endcase
      return r;
   endfunction

   function automatic logic [2:0] ref_sel(input logic [7:0] op);
      case (op)
         8'h02, 8'h03: return 3'd1;
         8'h04:        return 3'd2;
         8'h05:        return 3'd3;
         8'h06:        return 3'd4;
         default:      return 3'd0;
      endcase
   endfunction

   function automatic logic [7:0] ref_d2(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         8'h01:   r = a;
         8'h03:   r = 8'd0 - b;
         8'h06:   r = 8'((b % 8) * 32);
         default: r = b;
      endcase
      return r;
   endfunction

   function automatic int ref_wait(input logic [7:0] op);
      return (op == 8'h02 || op == 8'h03) ? 2 : 1;
   endfunction

   // Monitor: pops one expectation per result presented, then checks it stays stable in HOLD.
   bit         seen = 0;
   logic [7:0] held_d;
   logic       held_z;
   exp_t       m_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 0;
      end else if (res_valid) begin
         if (!seen) begin
            seen   = 1;
            held_d = res_data;
            held_z = res_zero;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %0h expected no result (t=%0t)", res_data, $time);
            end else begin
               m_e = q.pop_front();
               chk("res_data", 32'(res_data), 32'(m_e.data));
               chk("res_zero", 32'(res_zero), 32'(m_e.zero));
               chk("latency", 32'(cyc), 32'(m_e.due));
            end
         end else begin
            chk("hold_stable", {23'd0, res_zero, res_data}, {23'd0, held_z, held_d});
         end
         if (res_ready) hs_cyc = cyc + 1;
      end else begin
         seen = 0;
      end
   end

   task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      int         n;
      int         acc;
      logic [7:0] pd1;
      logic [7:0] pd2;
      logic [2:0] ps;
      exp_t       e;
      logic [7:0] r;
      @(negedge clk);
      instr_valid = 1'b1;
      opcode      = op;
      op1         = a;
      op2         = b;
      n = 0;
      while (!instr_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got instr_ready 0 expected 1 (op %0h)", op);
         instr_valid = 1'b0;
         return;
      end
      pd1 = alu_d1;
      pd2 = alu_d2;
      ps  = alu_sel;
      acc = cyc + 1;
      if (is_legal(op)) begin
         r      = ref_result(op, a, b);
         e.data = r;
         e.zero = (r == 8'd0);
         e.due  = acc + ref_wait(op);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      last_acc    = acc;
      if (is_legal(op)) begin
         chk("alu_select", 32'(alu_sel), 32'(ref_sel(op)));
         chk("alu_data1", 32'(alu_d1), 32'(a));
         chk("alu_data2", 32'(alu_d2), 32'(ref_d2(op, a, b)));
         chk("busy_ready", 32'(instr_ready), 32'd0);
         chk("no_illegal", 32'(illegal), 32'd0);
      end else begin
         chk("illegal_pulse", 32'(illegal), 32'd1);
         chk("err_ready", 32'(instr_ready), 32'd0);
         chk("err_alu_sel", 32'(alu_sel), 32'(ps));
         chk("err_alu_d1", 32'(alu_d1), 32'(pd1));
         chk("err_alu_d2", 32'(alu_d2), 32'(pd2));
         @(posedge clk);
         #1;
         chk("illegal_end", 32'(illegal), 32'd0);
         chk("err_ready_back", 32'(instr_ready), 32'd1);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
      chk({tag, "_alu_d1"}, 32'(alu_d1), 32'd0);
      chk({tag, "_alu_d2"}, 32'(alu_d2), 32'd0);
      chk({tag, "_res_data"}, 32'(res_data), 32'd0);
      chk({tag, "_res_zero"}, 32'(res_zero), 32'd0);
      chk({tag, "_illegal"}, 32'(illegal), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [7:0] rop;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      opcode      = 8'h00;
      op1         = 8'h00;
      op2         = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_vals("por");

      // Directed ops: wrap, SUB negation, shift placement, pass-through, illegal.
      issue(8'h02, 8'h7F, 8'h01);
      issue(8'h02, 8'hFF, 8'h01);
      issue(8'h03, 8'h05, 8'h05);
      issue(8'h03, 8'h03, 8'h05);
      issue(8'h06, 8'hB4, 8'h03);
      issue(8'h04, 8'hF0, 8'h3C);
      issue(8'h05, 8'hF0, 8'h0F);
      issue(8'h00, 8'h00, 8'h5A);
      issue(8'h01, 8'h33, 8'h00);
      issue(8'h09, 8'h12, 8'h34);

      // Consumer stalls in HOLD while the next instruction waits at the input.
      @(posedge clk);
      #1;
      rdy_mode = 1;
      issue(8'h02, 8'h10, 8'h20);
      n = 0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid", 32'(res_valid), 32'd1);
      @(negedge clk);
      instr_valid = 1'b1;
      opcode      = 8'h04;
      op1         = 8'hAA;
      op2         = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", 32'(instr_ready), 32'd0);
         chk("stall_sel", 32'(alu_sel), 32'd1);
      end
      @(posedge clk);
      #1;
      rdy_mode = 2;
      issue(8'h04, 8'hAA, 8'h0F);
      chk("accept_after_hs", 32'(last_acc), 32'(hs_cyc + 1));

      // Reset while an ADD is still settling: everything returns to reset values at once.
      issue(8'h02, 8'h01, 8'h02);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_vals("postrst");
      issue(8'h02, 8'h20, 8'h22);

      // Random traffic with random consumer backpressure.
      @(posedge clk);
      #1;
      rdy_mode = 0;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) rop = 8'($urandom_range(7, 255));
         else                           rop = 8'($urandom_range(0, 6));
         issue(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(q.size()), 32'd0);
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
